// File: rtl/dbg_abstract_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// dbg_abstract_cmd_ctrl
//
// Debug-module controller for one hart. It accepts RISC-V Access Register
// abstract commands, validates them against the core state, and drives the
// core's abstract register port. Read data is captured into data0. It also
// runs the resume handshake and the registered halt request.
//
// Optional feature macro: DBG_AUTOINCR_EN
//   defined   : aarpostincrement is legal. The latched regno is incremented
//               after a successful access or a transfer=0 command. Re-issuing
//               the identical command word then uses the stored regno.
//   undefined : aarpostincrement=1 is rejected as "not supported".
//
// Parameters
//   AR_TIMEOUT : read-data wait limit (8-bit counter) before cmderr=3
//   MAX_REGNO  : highest legal regno (CSRs 0x0000-0x0FFF, GPRs 0x1000-0x101F)
//
// Ports
//   clk_i, reset_ni             : clock, async active-low reset
//   cmd_valid_i, cmd_i          : DMI write pulse to "command" and its word
//   cmderr_clr_i                : W1C mask for cmderr
//   data0_we_i, data0_wdata_i   : DMI write to data0
//   data0_o, busy_o, cmderr_o   : abstract status back to the DM
//   resumereq_i, haltreq_i      : dmcontrol resume pulse / halt level
//   allresumeack_o              : sticky resume acknowledge
//   dbg_haltreq_o/resumereq_o   : run-control requests to the core
//   core_halted_i/resumeack_i   : core run-control status
//   dbg_ar_*                    : abstract register access port to the core
// -----------------------------------------------------------------------------
module dbg_abstract_cmd_ctrl #(
  parameter int          AR_TIMEOUT = 255,
  parameter logic [15:0] MAX_REGNO  = 16'h101F
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic [2:0]  cmderr_clr_i,
  input  logic        data0_we_i,
  input  logic [31:0] data0_wdata_i,
  output logic [31:0] data0_o,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  input  logic        resumereq_i,
  input  logic        haltreq_i,
  output logic        allresumeack_o,
  output logic        dbg_haltreq_o,
  output logic        dbg_resumereq_o,
  input  logic        core_halted_i,
  input  logic        core_resumeack_i,
  output logic        dbg_ar_en_o,
  output logic        dbg_ar_wr_o,
  output logic [15:0] dbg_ar_ad_o,
  output logic [31:0] dbg_ar_do_o,
  input  logic [31:0] dbg_ar_di_i,
  input  logic        dbg_ar_rvalid_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_e;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_BUSY   = 3'd1;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_EXCEPT = 3'd3;
  localparam logic [2:0] ERR_HALTRS = 3'd4;

  localparam logic [7:0] TIMEOUT_C = 8'(AR_TIMEOUT);

`ifdef DBG_AUTOINCR_EN
  localparam logic AUTOINCR_C = 1'b1;
`else
  localparam logic AUTOINCR_C = 1'b0;
`endif

  // Command word legality independent of core state.
  function automatic logic cmd_unsupported(input logic [31:0] cmd,
                                           input logic [15:0] regno);
    logic bad;
    bad = (cmd[31:24] != 8'd0) || (cmd[22:20] != 3'd2) || cmd[18] ||
          (regno > MAX_REGNO) || (cmd[19] && !AUTOINCR_C);
    return bad;
  endfunction

  state_e      state_r;
  logic [7:0]  cnt_r;
  logic        busy_r;
  logic [2:0]  cmderr_r;
  logic [31:0] data0_r;
  logic        haltreq_r;
  logic        resume_pend_r;
  logic        allresumeack_r;
  logic        ar_en_r;
  logic        ar_wr_r;
  logic [15:0] ar_ad_r;
  logic [31:0] ar_do_r;
  logic        write_r;
`ifdef DBG_AUTOINCR_EN
  logic [15:0] regno_r;
  logic [31:0] last_cmd_r;
  logic        incr_vld_r;
  logic        postinc_r;
`endif

  logic [15:0] regno_eff_s;
  logic        accept_s;
  logic        unsup_s;
  logic        state_bad_s;
  logic        launch_s;
  logic        nop_s;
  logic        timeout_s;
  logic        capture_s;
  logic        resume_ok_s;
  logic [2:0]  new_err_s;
  logic [2:0]  cmderr_nxt_s;
  logic [31:0] data0_nxt_s;

  // Effective regno: the stored post-incremented value replaces the field
  // only when the exact same command word is written again.
  always_comb begin
    regno_eff_s = cmd_i[15:0];
`ifdef DBG_AUTOINCR_EN
    if (incr_vld_r && cmd_i[19] && (cmd_i == last_cmd_r)) begin
      regno_eff_s = regno_r;
    end else begin
      regno_eff_s = cmd_i[15:0];
    end
`endif
  end

  // Command acceptance decode, error selection and data0 next value.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && cmd_valid_i && (cmderr_r == ERR_NONE);
    unsup_s     = cmd_unsupported(cmd_i, regno_eff_s);
    state_bad_s = !core_halted_i || resume_pend_r;
    launch_s    = accept_s && !unsup_s && !state_bad_s && cmd_i[17];
    nop_s       = accept_s && !unsup_s && !state_bad_s && !cmd_i[17];
    capture_s   = (state_r == ST_RDWAIT) && dbg_ar_rvalid_i;
    timeout_s   = (state_r == ST_RDWAIT) && !dbg_ar_rvalid_i && (cnt_r == TIMEOUT_C);
    resume_ok_s = resumereq_i && !haltreq_i && core_halted_i && !busy_r;

    // Exception of the running command ranks above a busy collision.
    if (accept_s && unsup_s) begin
      new_err_s = ERR_NOTSUP;
    end else if (accept_s && state_bad_s) begin
      new_err_s = ERR_HALTRS;
    end else if (timeout_s) begin
      new_err_s = ERR_EXCEPT;
    end else if (busy_r && (cmd_valid_i || data0_we_i)) begin
      new_err_s = ERR_BUSY;
    end else begin
      new_err_s = ERR_NONE;
    end

    // Sticky: a new code lands only on a clear cmderr, and then beats W1C.
    if ((new_err_s != ERR_NONE) && (cmderr_r == ERR_NONE)) begin
      cmderr_nxt_s = new_err_s;
    end else begin
      cmderr_nxt_s = cmderr_r & ~cmderr_clr_i;
    end

    // A read capture beats a DMI write; DMI writes are ignored while busy.
    if (capture_s) begin
      data0_nxt_s = dbg_ar_di_i;
    end else if (data0_we_i && !busy_r) begin
      data0_nxt_s = data0_wdata_i;
    end else begin
      data0_nxt_s = data0_r;
    end
  end

  // Controller FSM, status registers, resume handshake and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 8'd0;
      busy_r         <= 1'b0;
      cmderr_r       <= ERR_NONE;
      data0_r        <= 32'd0;
      haltreq_r      <= 1'b0;
      resume_pend_r  <= 1'b0;
      allresumeack_r <= 1'b0;
      ar_en_r        <= 1'b0;
      ar_wr_r        <= 1'b0;
      ar_ad_r        <= 16'd0;
      ar_do_r        <= 32'd0;
      write_r        <= 1'b0;
`ifdef DBG_AUTOINCR_EN
      regno_r        <= 16'd0;
      last_cmd_r     <= 32'd0;
      incr_vld_r     <= 1'b0;
      postinc_r      <= 1'b0;
`endif
    end else begin
      cmderr_r  <= cmderr_nxt_s;
      data0_r   <= data0_nxt_s;
      haltreq_r <= haltreq_i;

      if (resume_ok_s) begin
        resume_pend_r  <= 1'b1;
        allresumeack_r <= 1'b0;
      end else if (resume_pend_r && core_resumeack_i) begin
        resume_pend_r  <= 1'b0;
        allresumeack_r <= 1'b1;
      end else begin
        resume_pend_r  <= resume_pend_r;
        allresumeack_r <= allresumeack_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            state_r <= ST_ACCESS;
            busy_r  <= 1'b1;
            ar_en_r <= 1'b1;
            ar_wr_r <= cmd_i[16];
            ar_ad_r <= regno_eff_s;
            ar_do_r <= data0_nxt_s;
            write_r <= cmd_i[16];
`ifdef DBG_AUTOINCR_EN
            regno_r    <= regno_eff_s;
            last_cmd_r <= cmd_i;
            postinc_r  <= cmd_i[19];
            incr_vld_r <= 1'b0;
`endif
          end else if (nop_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
`ifdef DBG_AUTOINCR_EN
            if (cmd_i[19]) begin
              regno_r    <= regno_eff_s + 16'd1;
              last_cmd_r <= cmd_i;
              incr_vld_r <= 1'b1;
            end else begin
              incr_vld_r <= 1'b0;
            end
`endif
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        ST_ACCESS: begin
          ar_en_r <= 1'b0;
          ar_wr_r <= 1'b0;
          ar_ad_r <= 16'd0;
          ar_do_r <= 32'd0;
          cnt_r   <= 8'd0;
          if (write_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
`ifdef DBG_AUTOINCR_EN
            if (postinc_r) begin
              regno_r    <= regno_r + 16'd1;
              incr_vld_r <= 1'b1;
            end else begin
              incr_vld_r <= 1'b0;
            end
`endif
          end else begin
            state_r <= ST_RDWAIT;
          end
        end

        ST_RDWAIT: begin
          if (capture_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
`ifdef DBG_AUTOINCR_EN
            if (postinc_r) begin
              regno_r    <= regno_r + 16'd1;
              incr_vld_r <= 1'b1;
            end else begin
              incr_vld_r <= 1'b0;
            end
`endif
          end else if (timeout_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          ar_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign data0_o         = data0_r;
  assign busy_o          = busy_r;
  assign cmderr_o        = cmderr_r;
  assign allresumeack_o  = allresumeack_r;
  assign dbg_haltreq_o   = haltreq_r;
  assign dbg_resumereq_o = resume_pend_r;
  assign dbg_ar_en_o     = ar_en_r;
  assign dbg_ar_wr_o     = ar_wr_r;
  assign dbg_ar_ad_o     = ar_ad_r;
  assign dbg_ar_do_o     = ar_do_r;

endmodule
